// File: rtl/delay_sched_pkg.sv
// Shared types and sizing helpers for the delay_sched controller and its tap line.
package delay_sched_pkg;

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   function automatic int cw_of(input int dmax);
      return $clog2(dmax + 1);
   endfunction

endpackage

// File: rtl/delay_tap_line.sv
// DMAX-deep {valid,data} shift register with shift enable and a selectable output tap.
// A beat's valid bit is cleared as it leaves the tap, so a later, longer delay never re-emits it.
module delay_tap_line #(
   parameter int DMAX = 16,
   parameter int DW   = 32,
   parameter int CW   = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_vld,
   input  logic [DW-1:0] in_data,
   input  logic [CW-1:0] sel,
   output logic          out_vld,
   output logic [DW-1:0] out_data
);

   logic [DMAX-1:0] vld_p;
   logic [DW-1:0]   dat_p [DMAX];

   // Stage boundary: valid bits, cleared on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else if (en) begin
         vld_p[0] <= in_vld;
         for (int i = 1; i < DMAX; i++) begin
            vld_p[i] <= vld_p[i-1] && (int'(sel) != i - 1);
         end
      end
   end

   // Stage boundary: data payload, never reset
   always_ff @(posedge clk) begin
      if (en) begin
         dat_p[0] <= in_data;
         for (int i = 1; i < DMAX; i++) begin
            dat_p[i] <= dat_p[i-1];
         end
      end
   end

   always_comb begin
      out_vld  = 1'b0;
      out_data = '0;
      for (int i = 0; i < DMAX; i++) begin
         if (int'(sel) == i) begin
            out_vld  = vld_p[i];
            out_data = dat_p[i];
         end
      end
   end

endmodule

// File: rtl/delay_sched.sv
// Delay-line controller: runtime delay select with drain-before-reconfigure safety.
// Optional stall port enabled by macro DELAY_SCHED_STALL_EN.
module delay_sched
   import delay_sched_pkg::*;
#(
   parameter int DMAX      = 16,
   parameter int DW        = 32,
   parameter int DEF_DELAY = 2,
   parameter int CW        = cw_of(DMAX)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef DELAY_SCHED_STALL_EN
   input  logic          stall,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic [CW-1:0] cfg_delay,
   input  logic          cfg_wr,
   output logic          cfg_busy,
   output logic          cfg_err,
   output logic [CW-1:0] cur_delay
);

   state_t        state, state_nx;
   logic          adv, accept, cfg_ok, tap_vld;
   logic [DW-1:0] tap_dat;
   logic [CW-1:0] pend_delay, inflight, tap_sel;

`ifdef DELAY_SCHED_STALL_EN
   assign adv = ~stall;
`else
   assign adv = 1'b1;
`endif

   assign cfg_ok    = cfg_wr && (state == RUN) && (cfg_delay != '0) && (cfg_delay <= CW'(DMAX));
   assign in_ready  = (state == RUN) && adv;
   assign accept    = in_valid && in_ready;
   assign tap_sel   = cur_delay - CW'(1);
   assign out_valid = tap_vld && adv;
   assign out_data  = out_valid ? tap_dat : '0;
   assign cfg_busy  = (state == DRAIN) || (state == LOAD);

   delay_tap_line #(.DMAX(DMAX), .DW(DW), .CW(CW)) u_tap (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .in_vld   (accept),
      .in_data  (in_data),
      .sel      (tap_sel),
      .out_vld  (tap_vld),
      .out_data (tap_dat)
   );

   always_comb begin
      state_nx = state;
      case (state)
         RUN:     if (cfg_ok) state_nx = DRAIN;
         DRAIN:   if (adv && inflight == '0) state_nx = LOAD;
         LOAD:    if (adv) state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // A request may enter DRAIN while stalled; only drain completion and LOAD wait for the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         cur_delay  <= CW'(DEF_DELAY);
         pend_delay <= CW'(DEF_DELAY);
         inflight   <= '0;
         cfg_err    <= 1'b0;
      end else begin
         state   <= state_nx;
         cfg_err <= cfg_wr && !cfg_ok;
         if (cfg_ok) pend_delay <= cfg_delay;
         if (state == LOAD && adv) cur_delay <= pend_delay;
         if (accept && !out_valid)      inflight <= inflight + CW'(1);
         else if (!accept && out_valid) inflight <= inflight - CW'(1);
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// Directed bench for delay_sched; the stall scenario is built only with DELAY_SCHED_STALL_EN.
module tb_delay_sched;

   localparam int DMAX = 16;
   localparam int DW   = 32;
   localparam int CW   = 5;

   logic          clk = 1'b0;
   logic          rst, in_valid, cfg_wr;
   logic [DW-1:0] in_data;
   logic [CW-1:0] cfg_delay;
   logic          in_ready, out_valid, cfg_busy, cfg_err;
   logic [DW-1:0] out_data;
   logic [CW-1:0] cur_delay;
`ifdef DELAY_SCHED_STALL_EN
   logic          stall;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   delay_sched #(.DMAX(DMAX), .DW(DW), .DEF_DELAY(2)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef DELAY_SCHED_STALL_EN
      .stall     (stall),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .cfg_delay (cfg_delay),
      .cfg_wr    (cfg_wr),
      .cfg_busy  (cfg_busy),
      .cfg_err   (cfg_err),
      .cur_delay (cur_delay)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int peak;
      int idx;
      logic acc;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_wr = 1'b0; cfg_delay = '0;
`ifdef DELAY_SCHED_STALL_EN
      stall = 1'b0;
`endif
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  out_data,       32'd0);
      chk("rst_cfg_busy",  32'(cfg_busy),  32'd0);
      chk("rst_cfg_err",   32'(cfg_err),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_cur_delay", 32'(cur_delay), 32'd2);

      // Four beats at delay 2
      for (int k = 0; k < 8; k++) begin
         in_valid = (k < 4);
         in_data  = 32'hA0 + 32'(k);
         #1;
         chk("t1_out_valid", 32'(out_valid), (k >= 2 && k < 6) ? 32'd1 : 32'd0);
         chk("t1_out_data",  out_data, (k >= 2 && k < 6) ? 32'hA0 + 32'(k - 2) : 32'd0);
         cyc();
      end
      in_valid = 1'b0;
      chk("t1_inflight", 32'(dut.inflight), 32'd0);

      // Illegal delays rejected
      cfg_wr = 1'b1; cfg_delay = 5'd0;
      cyc();
      cfg_wr = 1'b0;
      #1;
      chk("t3_err_zero",   32'(cfg_err),   32'd1);
      chk("t3_busy_zero",  32'(cfg_busy),  32'd0);
      chk("t3_cur_zero",   32'(cur_delay), 32'd2);
      cyc();
      chk("t3_err_clear",  32'(cfg_err),   32'd0);
      cfg_wr = 1'b1; cfg_delay = 5'd17;
      cyc();
      cfg_wr = 1'b0;
      #1;
      chk("t3_err_17",     32'(cfg_err),   32'd1);
      chk("t3_busy_17",    32'(cfg_busy),  32'd0);
      chk("t3_cur_17",     32'(cur_delay), 32'd2);
      cyc();

      // Reconfigure to 5 with beats in flight; second request during DRAIN rejected
      for (int k = 0; k < 15; k++) begin
         in_valid  = (k <= 7);
         in_data   = (k <= 2) ? 32'h10 + 32'(k) : ((k <= 6) ? 32'hEE : 32'hB0);
         cfg_wr    = (k == 2) || (k == 4);
         cfg_delay = (k == 2) ? 5'd5 : 5'd7;
         #1;
         chk("t2_in_ready",  32'(in_ready),  (k >= 3 && k <= 6) ? 32'd0 : 32'd1);
         chk("t2_cfg_busy",  32'(cfg_busy),  (k >= 3 && k <= 6) ? 32'd1 : 32'd0);
         chk("t2_cfg_err",   32'(cfg_err),   (k == 5) ? 32'd1 : 32'd0);
         chk("t2_cur_delay", 32'(cur_delay), (k >= 7) ? 32'd5 : 32'd2);
         chk("t2_out_valid", 32'(out_valid), ((k >= 2 && k <= 4) || k == 12) ? 32'd1 : 32'd0);
         chk("t2_out_data",  out_data, (k >= 2 && k <= 4) ? 32'h10 + 32'(k - 2) :
                                        ((k == 12) ? 32'hB0 : 32'd0));
         cyc();
      end
      in_valid = 1'b0; cfg_wr = 1'b0;

      // Delay 16, 20 back-to-back beats
      cfg_wr = 1'b1; cfg_delay = 5'd16;
      #1;
      chk("t4_ready_req", 32'(in_ready), 32'd1);
      cyc();
      cfg_wr = 1'b0;
      #1;
      chk("t4_busy_drain", 32'(cfg_busy), 32'd1);
      cyc();
      chk("t4_busy_load",  32'(cfg_busy), 32'd1);
      cyc();
      chk("t4_busy_run",   32'(cfg_busy), 32'd0);
      chk("t4_cur_delay",  32'(cur_delay), 32'd16);
      peak = 0;
      for (int k = 0; k < 38; k++) begin
         in_valid = (k < 20);
         in_data  = 32'h100 + 32'(k);
         #1;
         chk("t4_in_ready",  32'(in_ready),  32'd1);
         chk("t4_out_valid", 32'(out_valid), (k >= 16 && k < 36) ? 32'd1 : 32'd0);
         chk("t4_out_data",  out_data, (k >= 16 && k < 36) ? 32'h100 + 32'(k - 16) : 32'd0);
         if (int'(dut.inflight) > peak) peak = int'(dut.inflight);
         cyc();
      end
      in_valid = 1'b0;
      chk("t4_peak",     32'(peak),          32'd16);
      chk("t4_inflight", 32'(dut.inflight),  32'd0);

      // Reset in the middle of DRAIN
      in_valid = 1'b1; in_data = 32'h200;
      cyc();
      in_data = 32'h201; cfg_wr = 1'b1; cfg_delay = 5'd2;
      cyc();
      in_valid = 1'b0; cfg_wr = 1'b0;
      #1;
      chk("t5_busy_pre", 32'(cfg_busy), 32'd1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_in_ready",  32'(in_ready),  32'd1);
      chk("t5_cur_delay", 32'(cur_delay), 32'd2);
      chk("t5_cfg_busy",  32'(cfg_busy),  32'd0);
      for (int k = 0; k < 20; k++) begin
         chk("t5_no_stale", 32'(out_valid), 32'd0);
         cyc();
      end

`ifdef DELAY_SCHED_STALL_EN
      // Three-cycle stall mid-stream shifts every output by three
      idx = 0;
      for (int k = 0; k < 13; k++) begin
         stall    = (k >= 2 && k <= 4);
         in_valid = (idx < 6);
         in_data  = 32'h30 + 32'(idx);
         #1;
         chk("t6_in_ready",  32'(in_ready),  (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
         chk("t6_out_valid", 32'(out_valid), (k >= 5 && k <= 10) ? 32'd1 : 32'd0);
         chk("t6_out_data",  out_data, (k >= 5 && k <= 10) ? 32'h30 + 32'(k - 5) : 32'd0);
         acc = in_valid && in_ready;
         cyc();
         if (acc) idx++;
      end
      stall = 1'b0; in_valid = 1'b0;
      chk("t6_inflight", 32'(dut.inflight), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
